// File: rtl/riscv_pc_alu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pc_alu_dmem
// Purpose  : Datapath core for a single-cycle RISC-V machine: program
//            counter, combinational 32-bit ALU and word-addressed data
//            memory.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous, active-low reset
//            pcnext       - advance PC by PC_STEP at the next edge
//            pc_reg       - current program counter
//            ALUctl       - ALU operation select
//            A, B         - ALU operands
//            ALUout, zero - ALU result and (ALUout == 0) flag
//            write_enable - store strobe (write at clock edge)
//            read_enable  - load strobe (combinational read)
//            address      - byte address; word index taken from it
//            write_data   - store data
//            read_data    - load data (0 when read_enable is low)
// Revision : 1.0 - initial release
// ============================================================================
module riscv_pc_alu_dmem #(
    parameter int MEM_WORDS = 256,
    parameter int PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcnext,
    output logic [31:0] pc_reg,
    input  logic [3:0]  ALUctl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUout,
    output logic        zero,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int          c_IDX_W   = $clog2(MEM_WORDS);
    localparam logic [31:0] c_PC_STEP = 32'(PC_STEP);

    localparam logic [3:0] c_OP_AND = 4'd0;
    localparam logic [3:0] c_OP_OR  = 4'd1;
    localparam logic [3:0] c_OP_ADD = 4'd2;
    localparam logic [3:0] c_OP_SUB = 4'd6;
    localparam logic [3:0] c_OP_SLT = 4'd7;
    localparam logic [3:0] c_OP_NOR = 4'd12;

    logic [31:0]        r_pc;
    logic [31:0]        r_mem [0:MEM_WORDS-1];
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_alu;
    logic               w_addr_unused;

    // ------------------------------------------------------------------
    // Program counter; natural 32-bit overflow gives the modulo-2^32 wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (pcnext) begin
            r_pc <= r_pc + c_PC_STEP;
        end
    end

    assign pc_reg = r_pc;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (ALUctl)
            c_OP_AND: w_alu = A & B;
            c_OP_OR:  w_alu = A | B;
            c_OP_ADD: w_alu = A + B;
            c_OP_SUB: w_alu = A - B;
            c_OP_SLT: w_alu = {31'd0, ($signed(A) < $signed(B))};
            c_OP_NOR: w_alu = ~(A | B);
            default:  w_alu = '0;
        endcase
    end

    assign ALUout = w_alu;
    assign zero   = (w_alu == 32'd0);

    // ------------------------------------------------------------------
    // Data memory. Byte-offset and upper address bits are dropped, so
    // accesses are whole words and addresses alias modulo MEM_WORDS*4.
    // Reset clears every word, which is why the array is built from
    // flops rather than a RAM macro.
    // ------------------------------------------------------------------
    assign w_idx         = address[c_IDX_W+1:2];
    assign w_addr_unused = ^{address[31:c_IDX_W+2], address[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (write_enable) begin
            r_mem[w_idx] <= write_data;
        end
    end

    // Read is asynchronous: a same-cycle store shows up only after the edge.
    assign read_data = read_enable ? r_mem[w_idx] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_pc_alu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_pc_alu_dmem
// Purpose  : Self-checking bench for riscv_pc_alu_dmem: table-driven ALU
//            vectors plus directed PC / memory sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_pc_alu_dmem;

    logic        clk;
    logic        reset;
    logic        pcnext;
    logic [31:0] pc_reg;
    logic [3:0]  ALUctl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUout;
    logic        zero;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int total;
    int bad;

    riscv_pc_alu_dmem #(
        .MEM_WORDS (256),
        .PC_STEP   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pcnext       (pcnext),
        .pc_reg       (pc_reg),
        .ALUctl       (ALUctl),
        .A            (A),
        .B            (B),
        .ALUout       (ALUout),
        .zero         (zero),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
    } alu_vec_t;

    localparam int c_NVEC = 14;
    alu_vec_t vecs [0:c_NVEC-1];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One rising edge; returns at the following falling edge with inputs
    // free to change and outputs stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  32'd12,         32'd10, 32'd8,          1'b0};
        vecs[1]  = '{4'd1,  32'd12,         32'd10, 32'd14,         1'b0};
        vecs[2]  = '{4'd2,  32'd12,         32'd10, 32'd22,         1'b0};
        vecs[3]  = '{4'd6,  32'd12,         32'd10, 32'd2,          1'b0};
        vecs[4]  = '{4'd6,  32'd5,          32'd5,  32'd0,          1'b1};
        vecs[5]  = '{4'd7,  32'hFFFFFFFF,   32'd1,  32'd1,          1'b0};
        vecs[6]  = '{4'd7,  32'd1,          32'hFFFFFFFF, 32'd0,    1'b1};
        vecs[7]  = '{4'd12, 32'd0,          32'd0,  32'hFFFFFFFF,   1'b0};
        vecs[8]  = '{4'd12, 32'hF0F0F0F0,   32'h0000FFFF, 32'h0F0F0000, 1'b0};
        vecs[9]  = '{4'd3,  32'd12,         32'd10, 32'd0,          1'b1};
        vecs[10] = '{4'd15, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,    1'b1};
        vecs[11] = '{4'd2,  32'hFFFFFFFF,   32'd1,  32'd0,          1'b1};
        vecs[12] = '{4'd6,  32'd0,          32'd1,  32'hFFFFFFFF,   1'b0};
        vecs[13] = '{4'd7,  32'd3,          32'd7,  32'd1,          1'b0};

        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        pcnext       = 1'b1;
        ALUctl       = 4'd0;
        A            = '0;
        B            = '0;
        write_enable = 1'b1;
        read_enable  = 1'b0;
        address      = 32'd8;
        write_data   = 32'h11111111;

        // Reset for two edges; step and store requests must be ignored.
        @(negedge clk);
        tick();
        tick();
        write_enable = 1'b0;
        read_enable  = 1'b1;
        #1;
        check32("reset_pc", pc_reg, 32'd0);
        check32("reset_mem", read_data, 32'd0);

        // Step three times, then hold.
        reset       = 1'b1;
        read_enable = 1'b0;
        pcnext      = 1'b1;
        tick(); check32("pc_step1", pc_reg, 32'd4);
        tick(); check32("pc_step2", pc_reg, 32'd8);
        tick(); check32("pc_step3", pc_reg, 32'd12);
        pcnext = 1'b0;
        tick(); check32("pc_hold", pc_reg, 32'd12);

        // ALU table.
        for (int i = 0; i < c_NVEC; i++) begin
            ALUctl = vecs[i].ctl;
            A      = vecs[i].a;
            B      = vecs[i].b;
            #1;
            check32($sformatf("alu_out[%0d]", i), ALUout, vecs[i].exp_out);
            check32($sformatf("alu_zero[%0d]", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
        end

        // Store then load, including ignored byte offset.
        write_enable = 1'b1;
        address      = 32'd8;
        write_data   = 32'hDEADBEEF;
        tick();
        write_enable = 1'b0;
        read_enable  = 1'b1;
        #1; check32("load_8", read_data, 32'hDEADBEEF);
        address = 32'd11;
        #1; check32("load_11", read_data, 32'hDEADBEEF);
        read_enable = 1'b0;
        #1; check32("load_disabled", read_data, 32'd0);

        // Aliasing: 0x400 folds onto word 0.
        write_enable = 1'b1;
        address      = 32'h400;
        write_data   = 32'h1234;
        tick();
        write_enable = 1'b0;
        read_enable  = 1'b1;
        address      = 32'd0;
        #1; check32("alias_load", read_data, 32'h1234);
        address = 32'd4;
        #1; check32("alias_neighbour", read_data, 32'd0);

        // Simultaneous load and store at one address.
        read_enable  = 1'b0;
        write_enable = 1'b1;
        address      = 32'h10;
        write_data   = 32'h77;
        tick();
        read_enable = 1'b1;
        write_data  = 32'h55;
        #1; check32("rw_before_edge", read_data, 32'h77);
        tick();
        write_enable = 1'b0;
        #1; check32("rw_after_edge", read_data, 32'h55);

        // Bring PC to 0x20 while rewriting word 2 to 0xAA.
        read_enable = 1'b0;
        pcnext      = 1'b1;
        tick(); tick(); tick(); tick();
        write_enable = 1'b1;
        address      = 32'd8;
        write_data   = 32'hAA;
        tick();
        pcnext       = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b1;
        #1;
        check32("pre_reset_pc", pc_reg, 32'h20);
        check32("pre_reset_word2", read_data, 32'hAA);

        // Mid-run reset overrides concurrent step and store.
        reset        = 1'b0;
        pcnext       = 1'b1;
        write_enable = 1'b1;
        write_data   = 32'hBB;
        tick();
        reset        = 1'b1;
        pcnext       = 1'b0;
        write_enable = 1'b0;
        #1;
        check32("midreset_pc", pc_reg, 32'd0);
        check32("midreset_word2", read_data, 32'd0);
        address = 32'h10;
        #1; check32("midreset_word4", read_data, 32'd0);

        // PC wrap from a forced starting value.
        force dut.r_pc = 32'hFFFFFFFC;
        #1;
        release dut.r_pc;
        #1; check32("pc_forced", pc_reg, 32'hFFFFFFFC);
        pcnext = 1'b1;
        tick();
        pcnext = 1'b0;
        #1; check32("pc_wrap", pc_reg, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/riscv_pc_alu_dmem.md
# riscv_pc_alu_dmem

Datapath core for the single-cycle RISC-V machine: program counter, combinational ALU and word data memory in one block. The control unit drives the ALU operands and opcode, steps the PC once per instruction, and uses the ALU result as the load/store address. Instruction memory, register file and immediate extension are outside this block.

## Interface
Parameters:
- MEM_WORDS, 256: data memory depth in 32-bit words (power of two).
- PC_STEP, 4: PC increment per step.

Ports:
- clk  in  1  single clock, rising-edge active.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- pcnext  in  1  step PC at the next edge.
- pc_reg  out  32  current PC.
- ALUctl  in  4  ALU operation select.
- A  in  32  ALU operand 1.
- B  in  32  ALU operand 2 (register data or extended immediate).
- ALUout  out  32  ALU result.
- zero  out  1  high when ALUout == 0.
- write_enable  in  1  memory store strobe.
- read_enable  in  1  memory load strobe.
- address  in  32  byte address for load/store.
- write_data  in  32  store data.
- read_data  out  32  load data.

## Operation
- PC: on an edge with reset high and pcnext=1, pc_reg <= pc_reg + PC_STEP, modulo 2^32 (0xFFFFFFFC + 4 wraps to 0). pcnext=0 holds pc_reg.
- ALU, purely combinational, 32-bit:
  - 0 AND, 1 OR, 2 ADD, 6 SUB (A - B), 7 SLT (signed; result 1 or 0), 12 NOR.
  - Any other code gives 0.
  - ADD/SUB wrap modulo 2^32 with no overflow flag.
  - zero = (ALUout == 0), including for unsupported codes.
- Data memory: MEM_WORDS x 32 array. Word index = address[log2(MEM_WORDS)+1:2].
  - address[1:0] are ignored, so there are no byte or half-word accesses.
  - Upper address bits are ignored, so addresses alias modulo MEM_WORDS*4.
- Store: on an edge with reset high and write_enable=1, mem[index] <= write_data.
- Load: read_data = mem[index] combinationally while read_enable=1. read_data = 0 while read_enable=0.
- write_enable and read_enable both high is legal. The read returns the pre-edge contents until the edge, then the newly written word.

## Timing
- Reset (reset=0 at a rising edge):
  - pc_reg <= 0.
  - Every memory word <= 0.
  - pcnext and write_enable are ignored on that edge.
  - ALUout and zero stay combinational from A, B and ALUctl.
  - read_data reads 0 after reset (memory cleared).
- Reset asserted mid-operation overrides a concurrent PC step or store on the same edge.
- ALU latency: 0 cycles, combinational.
- Load latency: 0 cycles. read_data follows address and read_enable within the same cycle.
- Store latency: the write completes at the edge where write_enable is sampled high. It is visible to a load in the following cycle.
- PC step latency: 1 edge. pc_reg changes only on clk edges.
- No handshakes. One instruction per cycle when pcnext is held high.

## Test plan
- Reset then step: hold reset=0 for 2 edges, then reset=1 with pcnext=1 for 3 edges. Required pc_reg: 0, 4, 8, 12. With pcnext=0 for 1 edge, pc_reg holds 12.
- ALU ops with A=12, B=10:
  - ALUctl=0 -> 8; 1 -> 14; 2 -> 22; 6 -> 2 with zero=0.
  - A=B=5 with ALUctl=6 -> 0 with zero=1.
  - A=-1, B=1 with ALUctl=7 -> 1.
  - ALUctl=12, A=0, B=0 -> 0xFFFFFFFF.
  - ALUctl=3 -> 0 with zero=1.
- Store/load: write_enable=1, address=8, write_data=0xDEADBEEF for 1 edge. Then read_enable=1, address=8 gives 0xDEADBEEF. address=11 gives the same word. read_enable=0 gives 0.
- Aliasing and simultaneous access (MEM_WORDS=256):
  - Store 0x1234 at address 0x400, then load address 0 -> 0x1234.
  - Load and store 0x55 at the same address in one cycle: read_data shows the old value before the edge and 0x55 after.
- Reset mid-run: pc_reg=0x20 and memory word 2 = 0xAA, then reset=0 for 1 edge with pcnext=1 and write_enable=1. Required: pc_reg=0 and word 2 reads 0.
- Wrap: load pc_reg to 0xFFFFFFFC via steps or a forced initial state, then step once -> 0. ADD of 0xFFFFFFFF and 1 -> 0 with zero=1.
